// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register; resolves jumps/branches in ID and redirects the PC.
// Latency: one edge from pc to id_instr; a control transfer costs exactly one bubble.
// Backpressure: stall freezes PC, IF/ID and counters, and holds off redirects until it drops.
module fetch_stage #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     id_instr,
    output logic [5:0]      id_opcode,
    output logic [5:0]      id_funct,
    output logic [PC_W-1:0] id_pc_plus1,
    output logic            id_valid,
    input  logic            jump,
    input  logic            jr,
    input  logic            branch,
    input  logic            bne,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    output logic            redirect,
    output logic [31:0]     fetch_count,
    output logic [15:0]     flush_count
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] target;
    logic            eq;
    logic            taken;

    assign imem_addr = pc;
    assign pc_plus1  = pc + 1'b1;
    assign id_opcode = id_instr[31:26];
    assign id_funct  = id_instr[5:0];

    assign eq       = (rs_val == rt_val);
    assign taken    = branch & (bne ? ~eq : eq);
    assign redirect = id_valid & ~stall & (jump | taken);

    // jr arrives with jump set, so it must be tested first.
    always_comb begin
        target = id_pc_plus1 + id_instr[PC_W-1:0];
        if (jr) begin
            target = rs_val[PC_W-1:0];
        end else if (jump) begin
            target = id_instr[PC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            id_instr    <= '0;
            id_pc_plus1 <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
            flush_count <= '0;
        end else if (stall) begin
            pc          <= pc;
            id_instr    <= id_instr;
            id_pc_plus1 <= id_pc_plus1;
            id_valid    <= id_valid;
        end else if (redirect) begin
            // Wrong-path word is dropped; an all-zero instr decodes as sll $0 (NOP).
            pc          <= target;
            id_instr    <= '0;
            id_pc_plus1 <= target + 1'b1;
            id_valid    <= 1'b0;
            if (flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
        end else begin
            pc          <= pc_plus1;
            id_instr    <= imem_rdata;
            id_pc_plus1 <= pc_plus1;
            id_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: small imem model and a MIPS-style decoder feeding jump/jr/branch/bne.
module tb_fetch_stage;

    localparam int PC_W = 8;

    localparam logic [31:0] BEQ_I = 32'h1022_0003;  // beq $1,$2,+3
    localparam logic [31:0] BNE_I = 32'h1422_0003;  // bne $1,$2,+3
    localparam logic [31:0] J40_I = 32'h0800_0040;  // j 0x40
    localparam logic [31:0] J0_I  = 32'h0800_0000;  // j 0
    localparam logic [31:0] JR_I  = 32'h0020_0008;  // jr $1

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     id_instr;
    logic [5:0]      id_opcode;
    logic [5:0]      id_funct;
    logic [PC_W-1:0] id_pc_plus1;
    logic            id_valid;
    logic            jump, jr, branch, bne;
    logic [31:0]     rs_val, rt_val;
    logic            redirect;
    logic [31:0]     fetch_count;
    logic [15:0]     flush_count;

    logic [31:0] imem [256];
    int checks = 0;
    int errors = 0;

    fetch_stage #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_instr(id_instr), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_pc_plus1(id_pc_plus1), .id_valid(id_valid),
        .jump(jump), .jr(jr), .branch(branch), .bne(bne),
        .rs_val(rs_val), .rt_val(rt_val),
        .redirect(redirect), .fetch_count(fetch_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];

    always_comb begin
        jr     = (id_opcode == 6'd0) && (id_funct == 6'd8);
        jump   = (id_opcode == 6'd2) || (id_opcode == 6'd3) || jr;
        branch = (id_opcode == 6'd4) || (id_opcode == 6'd5);
        bne    = (id_opcode == 6'd5);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 256; i++) imem[i] = 32'h2000_0000 + i;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rs_val = '0; rt_val = '0;
        fill();
        tick(); tick();
        check("rst_addr", imem_addr, 0);
        check("rst_instr", id_instr, 0);
        check("rst_pcp1", id_pc_plus1, 0);
        check("rst_valid", id_valid, 0);
        check("rst_fetch", fetch_count, 0);
        check("rst_flush", flush_count, 0);
        check("rst_redir", redirect, 0);
        rst = 1'b0;

        // free-running fetch
        for (int c = 0; c < 4; c++) begin
            check("seq_addr", imem_addr, c);
            tick();
            check("seq_instr", id_instr, 32'h2000_0000 + c);
        end
        check("seq_fetch", fetch_count, 4);

        // taken beq at PC 5, imm 3 -> target 9
        imem[5] = BEQ_I; rs_val = 7; rt_val = 7;
        do_reset();
        repeat (6) tick();
        check("beq_instr", id_instr, BEQ_I);
        check("beq_pcp1", id_pc_plus1, 6);
        check("beq_redir", redirect, 1);
        tick();
        check("beq_addr", imem_addr, 9);
        check("beq_valid", id_valid, 0);
        check("beq_nop", id_instr, 0);
        check("beq_tpcp1", id_pc_plus1, 10);
        check("beq_flush", flush_count, 1);
        tick();
        check("beq_tgt_instr", id_instr, 32'h2000_0009);
        check("beq_fetch", fetch_count, 7);

        // not-taken beq
        rt_val = 8;
        do_reset();
        repeat (6) tick();
        check("bnt_redir", redirect, 0);
        tick();
        check("bnt_addr", imem_addr, 7);
        check("bnt_instr", id_instr, 32'h2000_0006);
        check("bnt_valid", id_valid, 1);

        // bne with equal operands at PC 2, then j 0x40 at PC 3
        fill();
        imem[2] = BNE_I; imem[3] = J40_I; rs_val = 7; rt_val = 7;
        do_reset();
        repeat (3) tick();
        check("bne_instr", id_instr, BNE_I);
        check("bne_redir", redirect, 0);
        tick();
        check("j_addr_pre", imem_addr, 4);
        check("j_redir", redirect, 1);
        tick();
        check("j_addr", imem_addr, 8'h40);
        check("j_instr", id_instr, 0);
        check("j_pcp1", id_pc_plus1, 8'h41);

        // jr uses low PC_W bits of rs_val
        fill();
        imem[0] = JR_I; rs_val = 32'h1234_5612; rt_val = 0;
        do_reset();
        tick();
        check("jr_redir", redirect, 1);
        tick();
        check("jr_addr", imem_addr, 8'h12);

        // stall while a taken branch waits in IF/ID
        fill();
        imem[5] = BEQ_I; rs_val = 7; rt_val = 7;
        do_reset();
        repeat (6) tick();
        stall = 1'b1;
        #1;
        check("stl_redir0", redirect, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stl_addr", imem_addr, 6);
            check("stl_instr", id_instr, BEQ_I);
            check("stl_redir", redirect, 0);
            check("stl_fetch", fetch_count, 6);
            check("stl_flush", flush_count, 0);
        end
        stall = 1'b0;
        #1;
        check("stl_release_redir", redirect, 1);
        tick();
        check("stl_tgt_addr", imem_addr, 9);
        check("stl_tgt_flush", flush_count, 1);

        // reset coinciding with a redirect, then with a stall
        do_reset();
        repeat (6) tick();
        check("rr_redir", redirect, 1);
        rst = 1'b1;
        tick();
        check("rr_addr", imem_addr, 0);
        check("rr_valid", id_valid, 0);
        check("rr_flush", flush_count, 0);
        check("rr_fetch", fetch_count, 0);
        rst = 1'b0;
        repeat (6) tick();
        stall = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rs_addr", imem_addr, 0);
        check("rs_instr", id_instr, 0);
        check("rs_fetch", fetch_count, 0);
        rst = 1'b0; stall = 1'b0;

        // PC wraps 255 -> 0
        fill();
        do_reset();
        repeat (255) tick();
        check("wrap_addr255", imem_addr, 255);
        tick();
        check("wrap_addr0", imem_addr, 0);
        check("wrap_fetch", fetch_count, 256);

        // flush_count saturation: j 0 loops, one redirect every two cycles
        imem[0] = J0_I;
        do_reset();
        repeat (2 * 65534) tick();
        check("sat_fffe", flush_count, 16'hFFFE);
        repeat (2) tick();
        check("sat_ffff", flush_count, 16'hFFFF);
        repeat (2) tick();
        check("sat_hold", flush_count, 16'hFFFF);
        check("sat_fetch", fetch_count, 65536);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
